// File: rtl/instruction_dispatcher_pkg.sv
// Purpose: shared encodings for the instruction dispatcher (states, fmt/start codes, field positions).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RETIRE,
        ST_HALTED,
        ST_ERROR
    } state_t;

    // Instruction format codes carried in the top two bits of the word
    localparam logic [1:0] FMT_NOP  = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_IMM  = 2'b10;
    localparam logic [1:0] FMT_HALT = 2'b11;

    // Execution-FSM select codes; START_NONE is what FSM_start idles at
    localparam logic [3:0] START_NONE    = 4'b0000;
    localparam logic [3:0] START_REG_ALU = 4'b0001;
    localparam logic [3:0] START_IMM_ALU = 4'b0010;

    localparam int              WATCHDOG_WIDTH = 6;
    localparam logic [WATCHDOG_WIDTH-1:0] WATCHDOG_LIMIT = 6'd40;

    // Instruction word layout: fmt[17:16] opcode[15:12] param1[11:6] param2[5:0]
    localparam int INSTR_WIDTH = 18;
    localparam int FMT_MSB     = 17;
    localparam int FMT_LSB     = 16;
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;
    localparam int PARAM1_MSB  = 11;
    localparam int PARAM1_LSB  = 6;
    localparam int PARAM2_MSB  = 5;
    localparam int PARAM2_LSB  = 0;

endpackage

// File: rtl/dispatch_watchdog.sv
// Purpose: counts cycles spent waiting on an execution FSM and flags a timeout.
// Latency: expired is combinational, asserted during the WATCHDOG_LIMIT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module dispatch_watchdog
    import instruction_dispatcher_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WATCHDOG_WIDTH-1:0] count;

    // Count enabled cycles; saturate at the limit so the counter can never wrap
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != WATCHDOG_LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // The cycle in which the count would reach the limit is the expiry cycle
    assign expired = enable && (count == (WATCHDOG_LIMIT - 1'b1));

endmodule

// File: rtl/instruction_dispatcher.sv
// Purpose: fetches 18-bit instruction words, decodes them and launches the matching execution FSM.
// Latency: 2 cycles from instruction accept to FSM_start (DECODE, LAUNCH); pc advances on RETIRE entry.
// Backpressure: instr_ready only in FETCH; stalls in FETCH without instr_valid and in WAIT until done/timeout.
module instruction_dispatcher
    import instruction_dispatcher_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic                   instr_ready,
    output logic [7:0]             pc,
    output logic [3:0]             FSM_start,
    output logic [3:0]             opcode,
    output logic [5:0]             param1,
    output logic [5:0]             param2,
    input  logic                   done,
    output logic                   busy,
    output logic                   halted,
    output logic                   error
);

    state_t                 state;
    state_t                 state_nxt;
    logic [INSTR_WIDTH-1:0] instr_word;
    logic [1:0]             word_fmt;
    logic [3:0]             start_code;
    logic                   wd_clear;
    logic                   wd_enable;
    logic                   wd_expired;

    assign word_fmt = instr_word[FMT_MSB:FMT_LSB];

    dispatch_watchdog u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; done and run only matter in WAIT and IDLE
    always_comb begin
        state_nxt   = state;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
        instr_ready = 1'b0;
        FSM_start   = START_NONE;
        busy        = 1'b0;
        halted      = 1'b0;
        error       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy        = 1'b1;
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                busy = 1'b1;
                case (word_fmt)
                    FMT_NOP:  state_nxt = ST_RETIRE;
                    FMT_HALT: state_nxt = ST_HALTED;
                    default:  state_nxt = ST_LAUNCH;
                endcase
            end
            ST_LAUNCH: begin
                busy      = 1'b1;
                FSM_start = start_code;
                wd_clear  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy      = 1'b1;
                wd_enable = 1'b1;
                // done in the expiry cycle still retires the instruction
                if (done) begin
                    state_nxt = ST_RETIRE;
                end else if (wd_expired) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_RETIRE: begin
                busy      = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: word latch, decoded fields held until the next DECODE, pc bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= '0;
            instr_word <= '0;
            opcode     <= '0;
            param1     <= '0;
            param2     <= '0;
            start_code <= START_NONE;
        end else begin
            if ((state == ST_IDLE) && run) begin
                pc <= '0;
            end
            if ((state == ST_FETCH) && instr_valid) begin
                instr_word <= instr_data;
            end
            if (state == ST_DECODE) begin
                opcode <= instr_word[OPCODE_MSB:OPCODE_LSB];
                param1 <= instr_word[PARAM1_MSB:PARAM1_LSB];
                param2 <= instr_word[PARAM2_MSB:PARAM2_LSB];
                case (word_fmt)
                    FMT_REG: start_code <= START_REG_ALU;
                    FMT_IMM: start_code <= START_IMM_ALU;
                    default: start_code <= START_NONE;
                endcase
            end
            // pc moves to the next address as the instruction retires; 8-bit add wraps 255 -> 0
            if (((state == ST_DECODE) || (state == ST_WAIT)) && (state_nxt == ST_RETIRE)) begin
                pc <= pc + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Purpose: randomized scoreboard bench for instruction_dispatcher with directed boundary cases.
// Latency: expects FSM_start two cycles after accept; pc of next instruction visible in RETIRE.
// Backpressure: drives instr_valid only while instr_ready is high; done pulses on a chosen WAIT cycle.
module tb_instruction_dispatcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        instr_valid = 1'b0;
    logic [17:0] instr_data = '0;
    logic        done = 1'b0;
    logic        instr_ready;
    logic [7:0]  pc;
    logic [3:0]  FSM_start;
    logic [3:0]  opcode;
    logic [5:0]  param1;
    logic [5:0]  param2;
    logic        busy;
    logic        halted;
    logic        error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_pc = 0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] op;
        logic [5:0] p1;
        logic [5:0] p2;
        int         pc;
        int         cyc;
    } launch_t;

    launch_t exp_q[$];

    instruction_dispatcher dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .pc          (pc),
        .FSM_start   (FSM_start),
        .opcode      (opcode),
        .param1      (param1),
        .param2      (param2),
        .done        (done),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every launch is popped from the scoreboard and compared
    logic [3:0]  prev_start = 4'b0000;
    logic        inflight = 1'b0;
    logic [15:0] held_fields = '0;
    launch_t     mon_e;

    always @(negedge clock) begin
        if (FSM_start !== 4'b0000) begin
            if (prev_start !== 4'b0000) begin
                chk("launch_single_cycle", {28'd0, prev_start}, 32'd0);
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_launch: actual FSM_start=%0h required=0", FSM_start);
            end else begin
                mon_e = exp_q.pop_front();
                chk("launch_code",   {28'd0, FSM_start}, {28'd0, mon_e.code});
                chk("launch_opcode", {28'd0, opcode},    {28'd0, mon_e.op});
                chk("launch_param1", {26'd0, param1},    {26'd0, mon_e.p1});
                chk("launch_param2", {26'd0, param2},    {26'd0, mon_e.p2});
                chk("launch_pc",     {24'd0, pc},        mon_e.pc);
                chk("launch_cycle",  cyc,                mon_e.cyc);
                inflight    = 1'b1;
                held_fields = {mon_e.op, mon_e.p1, mon_e.p2};
            end
        end else if (inflight) begin
            if (instr_ready === 1'b1 || busy !== 1'b1) begin
                inflight = 1'b0;
            end else begin
                chk("fields_stable", {16'd0, opcode, param1, param2}, {16'd0, held_fields});
            end
        end
        prev_start = FSM_start;
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        run = 1'b0;
        instr_valid = 1'b0;
        done = 1'b0;
        @(negedge clock);
        chk("rst_pc",          {24'd0, pc},        0);
        chk("rst_fsm_start",   {28'd0, FSM_start}, 0);
        chk("rst_opcode",      {28'd0, opcode},    0);
        chk("rst_param1",      {26'd0, param1},    0);
        chk("rst_param2",      {26'd0, param2},    0);
        chk("rst_instr_ready", {31'd0, instr_ready}, 0);
        chk("rst_busy",        {31'd0, busy},      0);
        chk("rst_halted",      {31'd0, halted},    0);
        chk("rst_error",       {31'd0, error},     0);
        @(negedge clock);
        reset = 1'b0;
        model_pc = 0;
    endtask

    task automatic pulse_run();
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        chk("run_busy",  {31'd0, busy},        1);
        chk("run_pc",    {24'd0, pc},          0);
        chk("run_ready", {31'd0, instr_ready}, 1);
    endtask

    // done_k: WAIT cycle (1..40) carrying done; 0 = never; negative = stop in WAIT cycle (-done_k - 1)
    task automatic issue(input logic [1:0] fmt, input logic [3:0] op, input logic [5:0] p1,
                         input logic [5:0] p2, input int gap, input int done_k);
        int      n;
        int      c0;
        launch_t e;
        for (int i = 0; i < gap; i++) begin
            done = 1'($urandom_range(0, 1));
            run  = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        done = 1'b0;
        run = 1'b0;
        n = 0;
        while (instr_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (instr_ready !== 1'b1) begin
            chk("fetch_ready_timeout", {31'd0, instr_ready}, 1);
            return;
        end
        c0 = cyc;
        instr_valid = 1'b1;
        instr_data = {fmt, op, p1, p2};
        if (fmt == 2'b01 || fmt == 2'b10) begin
            e.code = (fmt == 2'b01) ? 4'b0001 : 4'b0010;
            e.op = op;
            e.p1 = p1;
            e.p2 = p2;
            e.pc = model_pc;
            e.cyc = c0 + 2;
            exp_q.push_back(e);
        end
        @(negedge clock);
        instr_valid = 1'b0;
        instr_data = 18'($urandom);
        @(negedge clock);
        if (fmt == 2'b00) begin
            model_pc = (model_pc + 1) % 256;
            chk("nop_pc", {24'd0, pc}, model_pc);
        end else if (fmt == 2'b11) begin
            chk("halt_halted", {31'd0, halted},      1);
            chk("halt_ready",  {31'd0, instr_ready}, 0);
            chk("halt_busy",   {31'd0, busy},        0);
            chk("halt_pc",     {24'd0, pc},          model_pc);
        end else if (done_k < 0) begin
            repeat (-done_k - 1) @(negedge clock);
        end else if (done_k == 0) begin
            repeat (40) @(negedge clock);
            chk("wd_last_wait_error", {31'd0, error}, 0);
            chk("wd_last_wait_busy",  {31'd0, busy},  1);
            @(negedge clock);
            chk("wd_error", {31'd0, error},       1);
            chk("wd_busy",  {31'd0, busy},        0);
            chk("wd_pc",    {24'd0, pc},          model_pc);
            chk("wd_ready", {31'd0, instr_ready}, 0);
        end else begin
            repeat (done_k) @(negedge clock);
            done = 1'b1;
            @(negedge clock);
            done = 1'b0;
            model_pc = (model_pc + 1) % 256;
            chk("retire_pc",    {24'd0, pc},    model_pc);
            chk("retire_error", {31'd0, error}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        logic [1:0] f;
        do_reset();
        pulse_run();

        // Immediate ALU word, done on WAIT cycle 13
        issue(2'b10, 4'd3, 6'd5, 6'd10, 0, 13);
        @(negedge clock);
        chk("first_retire_pc",    {24'd0, pc},          1);
        chk("first_back_in_fetch", {31'd0, instr_ready}, 1);

        // NOPs up to pc 4, then the NOP at pc 4
        while (model_pc != 4) issue(2'b00, 4'($urandom), 6'($urandom), 6'($urandom), 0, 0);
        issue(2'b00, 4'hf, 6'h3f, 6'h3f, 1, 0);
        chk("nop_at_4_pc", {24'd0, pc}, 5);

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            f = 2'($urandom_range(0, 2));
            k = $urandom_range(1, 40);
            if ($urandom_range(0, 7) == 0) k = 40;
            if ($urandom_range(0, 7) == 0) k = 1;
            issue(f, 4'($urandom), 6'($urandom), 6'($urandom), $urandom_range(0, 3), k);
        end

        // pc wrap on a retired NOP
        while (model_pc != 255) issue(2'b00, 4'($urandom), 6'($urandom), 6'($urandom), 0, 0);
        issue(2'b00, 4'd0, 6'd0, 6'd0, 0, 0);
        chk("wrap_pc", {24'd0, pc}, 0);

        // Register ALU word that never completes
        issue(2'b01, 4'd9, 6'd1, 6'd2, 0, 0);

        // HALT, then a run pulse that must be ignored
        do_reset();
        pulse_run();
        issue(2'b11, 4'd0, 6'd0, 6'd0, 0, 0);
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        chk("halt_run_ignored_halted", {31'd0, halted},      1);
        chk("halt_run_ignored_ready",  {31'd0, instr_ready}, 0);
        chk("halt_run_ignored_busy",   {31'd0, busy},        0);

        // Reset during WAIT cycle 5, then a stray done
        do_reset();
        pulse_run();
        issue(2'b01, 4'd7, 6'd33, 6'd12, 0, -5);
        chk("pre_reset_busy", {31'd0, busy}, 1);
        do_reset();
        @(negedge clock);
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        @(negedge clock);
        chk("post_reset_done_busy",  {31'd0, busy},        0);
        chk("post_reset_done_ready", {31'd0, instr_ready}, 0);
        chk("post_reset_done_pc",    {24'd0, pc},          0);
        chk("post_reset_done_error", {31'd0, error},       0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
